// File: rtl/pulse_train_gen.sv
// pulse_train_gen: registered pulse-train generator.
// A one-cycle START in IDLE launches PULSE_COUNT pulses. Each pulse is
// HIGH_CYCLES cycles high, and the pulses are separated by LOW_CYCLES cycles
// low. A HIGH or LOW length of 0 is run as 1 so that every edge can be seen by
// a two-flop edge detector downstream. There is no LOW phase after the last
// pulse.
// Optional build macro PULSE_TRAIN_CONTINUOUS_EN: when it is defined, a
// PULSE_COUNT of 0 runs an endless train that only ABORT or RSTN can stop.
// When it is not defined, a PULSE_COUNT of 0 gives a lone DONE strobe.
module pulse_train_gen #(
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          START,
  input  logic          ABORT,
  input  logic [CW-1:0] HIGH_CYCLES,
  input  logic [CW-1:0] LOW_CYCLES,
  input  logic [CW-1:0] PULSE_COUNT,
  output logic          PULSE_OUT,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Phase lengths latched at launch, already clamped to at least 1.
  typedef struct packed {
    logic [CW-1:0] hi_len;
    logic [CW-1:0] lo_len;
  } cfg_t;

  state_t        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [CW-1:0] phase_q, phase_d;   // cycles left in the current phase, minus 1
  logic [CW-1:0] rem_q, rem_d;       // pulses still to finish, including the current one
  logic          endless_q, endless_d;
  logic          done_d;
  logic          pulse_q, busy_q, done_q;

  logic          accept;
  logic [CW-1:0] hi_clamp, lo_clamp;

  // ABORT has priority over START, so START and ABORT together launch nothing.
  assign accept   = START && !ABORT;
  assign hi_clamp = (HIGH_CYCLES == '0) ? ONE : HIGH_CYCLES;
  assign lo_clamp = (LOW_CYCLES  == '0) ? ONE : LOW_CYCLES;

  // Next-state logic, counter updates and DONE generation.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    endless_d = endless_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cfg_d.hi_len = hi_clamp;
          cfg_d.lo_len = lo_clamp;
          phase_d      = hi_clamp - ONE;
          rem_d        = PULSE_COUNT;
          endless_d    = 1'b0;
          if (PULSE_COUNT != '0) begin
            state_d = HIGH;
          end else begin
`ifdef PULSE_TRAIN_CONTINUOUS_EN
            endless_d = 1'b1;
            state_d   = HIGH;
`else
            done_d    = 1'b1;
`endif
          end
        end
      end
      HIGH: begin
        if (ABORT) begin
          state_d   = IDLE;
          phase_d   = '0;
          rem_d     = '0;
          endless_d = 1'b0;
        end else if (phase_q != '0) begin
          phase_d = phase_q - ONE;
        end else if (endless_q) begin
          // An endless train never counts pulses down.
          state_d = LOW;
          phase_d = cfg_q.lo_len - ONE;
        end else if (rem_q > ONE) begin
          state_d = LOW;
          phase_d = cfg_q.lo_len - ONE;
          rem_d   = rem_q - ONE;
        end else begin
          // The last pulse goes straight back to IDLE, with no trailing gap.
          state_d = IDLE;
          rem_d   = rem_q - ONE;
          done_d  = 1'b1;
        end
      end
      LOW: begin
        if (ABORT) begin
          state_d   = IDLE;
          phase_d   = '0;
          rem_d     = '0;
          endless_d = 1'b0;
        end else if (phase_q != '0) begin
          phase_d = phase_q - ONE;
        end else begin
          state_d = HIGH;
          phase_d = cfg_q.hi_len - ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers. The outputs are decoded from the next state,
  // so they change on the same edge as the state and come straight from flops.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      phase_q   <= '0;
      rem_q     <= '0;
      endless_q <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      endless_q <= endless_d;
      pulse_q   <= (state_d == HIGH);
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
    end
  end

  assign PULSE_OUT = pulse_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen. A reference model builds the
// expected {PULSE_OUT,BUSY,DONE} sequence for a whole train as a queue when
// the train is launched. It then pops one entry per cycle, and an ABORT or a
// reset flushes the queue.
module tb_pulse_train_gen;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       START = 1'b1;
  logic       ABORT = 1'b0;
  logic [7:0] HIGH_CYCLES = '0;
  logic [7:0] LOW_CYCLES = '0;
  logic [7:0] PULSE_COUNT = '0;
  logic       PULSE_OUT, BUSY, DONE;

  int vecs = 0;
  int errs = 0;

  pulse_train_gen #(.CW(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .ABORT(ABORT),
    .HIGH_CYCLES(HIGH_CYCLES), .LOW_CYCLES(LOW_CYCLES), .PULSE_COUNT(PULSE_COUNT),
    .PULSE_OUT(PULSE_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: mq holds the expected {pulse,busy,done} of future cycles,
  // and exp_o is the value expected during the current cycle.
  logic [2:0] mq[$];
  logic [2:0] exp_o = 3'b000;

  task automatic build(input int h, input int l, input int n);
    int hh, ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    mq.delete();
    if (n == 0) begin
`ifdef PULSE_TRAIN_CONTINUOUS_EN
      for (int k = 0; k < 3000; k++) begin
        repeat (hh) mq.push_back(3'b110);
        repeat (ll) mq.push_back(3'b010);
      end
`else
      mq.push_back(3'b001);
`endif
    end else begin
      for (int i = 0; i < n; i++) begin
        repeat (hh) mq.push_back(3'b110);
        if (i < n - 1) repeat (ll) mq.push_back(3'b010);
      end
      mq.push_back(3'b001);
    end
  endtask

  // Advance the model at each clock edge, reading the same inputs the DUT sees.
  always @(posedge CLK) begin
    if (!RSTN) begin
      mq.delete();
      exp_o = 3'b000;
    end else if (!exp_o[1]) begin
      if (START && !ABORT) build(HIGH_CYCLES, LOW_CYCLES, PULSE_COUNT);
      exp_o = (mq.size() != 0) ? mq.pop_front() : 3'b000;
    end else if (ABORT) begin
      mq.delete();
      exp_o = 3'b000;
    end else begin
      exp_o = (mq.size() != 0) ? mq.pop_front() : 3'b000;
    end
  end

  task automatic test_reset;
    START = 1'b1; RSTN = 1'b0; HIGH_CYCLES = 8'd2; PULSE_COUNT = 8'd2;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== 3'b000) begin
        errs++; $display("FAIL reset c%0d got %b exp 000", c, {PULSE_OUT, BUSY, DONE});
      end
    end
    START = 1'b0; RSTN = 1'b1;
    @(negedge CLK);
    // Reset in the middle of a train clears everything, and no DONE follows.
    START = 1'b1; HIGH_CYCLES = 8'd3; LOW_CYCLES = 8'd1; PULSE_COUNT = 8'd3;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); RSTN = 1'b0;
    @(negedge CLK); RSTN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== 3'b000 || exp_o !== 3'b000) begin
        errs++; $display("FAIL reset_mid c%0d got %b exp 000", c, {PULSE_OUT, BUSY, DONE});
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_basic;
    logic [8:0] pexp;
    int busy_n;
    pexp = 9'b111001110;  // PULSE_OUT for cycles 1..9, MSB is cycle 1
    busy_n = 0;
    HIGH_CYCLES = 8'd3; LOW_CYCLES = 8'd2; PULSE_COUNT = 8'd2; START = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      START = 1'b0;
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o) begin
        errs++; $display("FAIL basic_model c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
      if (c <= 9) begin
        vecs++;
        if (PULSE_OUT !== pexp[9-c] || DONE !== (c == 9)) begin
          errs++; $display("FAIL basic_pattern c%0d got p=%b d=%b exp p=%b d=%b",
                           c, PULSE_OUT, DONE, pexp[9-c], (c == 9));
        end
      end
      if (BUSY === 1'b1) busy_n++;
    end
    vecs++;
    if (busy_n != 8) begin
      errs++; $display("FAIL basic_busy_len got %0d exp 8", busy_n);
    end
  endtask

  task automatic test_zero_clamp;
    logic [5:0] pexp;
    pexp = 6'b101010;  // PULSE_OUT for cycles 1..6
    HIGH_CYCLES = 8'd0; LOW_CYCLES = 8'd0; PULSE_COUNT = 8'd3; START = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      START = 1'b0;
      if (c == 2) begin HIGH_CYCLES = 8'd7; LOW_CYCLES = 8'd7; PULSE_COUNT = 8'd7; end
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o) begin
        errs++; $display("FAIL clamp_model c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
      if (c <= 6) begin
        vecs++;
        if (PULSE_OUT !== pexp[6-c] || DONE !== (c == 6)) begin
          errs++; $display("FAIL clamp_pattern c%0d got p=%b d=%b exp p=%b d=%b",
                           c, PULSE_OUT, DONE, pexp[6-c], (c == 6));
        end
      end
    end
  endtask

  task automatic test_abort;
    HIGH_CYCLES = 8'd4; LOW_CYCLES = 8'd4; PULSE_COUNT = 8'd5; START = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o) begin
        errs++; $display("FAIL abort_model c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
      if (c == 7) begin
        vecs++;
        if ({PULSE_OUT, BUSY, DONE} !== 3'b000) begin
          errs++; $display("FAIL abort_stop got %b exp 000", {PULSE_OUT, BUSY, DONE});
        end
      end
      if (c == 9) begin
        vecs++;
        if (PULSE_OUT !== 1'b1) begin
          errs++; $display("FAIL abort_restart got %b exp 1", PULSE_OUT);
        end
      end
      START = (c == 8);
      ABORT = (c == 6);
    end
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_collisions;
    int busy_n;
    busy_n = 0;
    // A START during a busy train is ignored: 3 pulses of 2 cycles with 1-cycle gaps give 8 busy cycles.
    HIGH_CYCLES = 8'd2; LOW_CYCLES = 8'd1; PULSE_COUNT = 8'd3; START = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      START = (c == 3);
      if (c == 3) begin HIGH_CYCLES = 8'd9; PULSE_COUNT = 8'd9; end
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o) begin
        errs++; $display("FAIL busy_start_model c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
      if (BUSY === 1'b1) busy_n++;
    end
    vecs++;
    if (busy_n != 8) begin
      errs++; $display("FAIL busy_start_len got %0d exp 8", busy_n);
    end
    // START and ABORT together in IDLE launch nothing.
    START = 1'b1; ABORT = 1'b1; HIGH_CYCLES = 8'd2; PULSE_COUNT = 8'd2;
    @(negedge CLK); START = 1'b0; ABORT = 1'b0;
    vecs++;
    if ({PULSE_OUT, BUSY, DONE} !== 3'b000 || exp_o !== 3'b000) begin
      errs++; $display("FAIL start_abort_idle got %b exp 000", {PULSE_OUT, BUSY, DONE});
    end
    // A START in the DONE cycle is accepted.
    HIGH_CYCLES = 8'd1; LOW_CYCLES = 8'd1; PULSE_COUNT = 8'd1; START = 1'b1;
    @(negedge CLK); START = 1'b0;  // cycle 1: high
    @(negedge CLK);                // cycle 2: DONE
    vecs++;
    if ({PULSE_OUT, BUSY, DONE} !== 3'b001) begin
      errs++; $display("FAIL done_cycle got %b exp 001", {PULSE_OUT, BUSY, DONE});
    end
    START = 1'b1;
    @(negedge CLK); START = 1'b0;
    vecs++;
    if (PULSE_OUT !== 1'b1 || {PULSE_OUT, BUSY, DONE} !== exp_o) begin
      errs++; $display("FAIL back_to_back got %b exp 110", {PULSE_OUT, BUSY, DONE});
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_count_zero;
    HIGH_CYCLES = 8'd1; LOW_CYCLES = 8'd1; PULSE_COUNT = 8'd0; START = 1'b1;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      START = 1'b0;
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o || PULSE_OUT !== c[0] || DONE !== 1'b0) begin
        errs++; $display("FAIL endless c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
    end
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    vecs++;
    if ({PULSE_OUT, BUSY, DONE} !== 3'b000) begin
      errs++; $display("FAIL endless_abort got %b exp 000", {PULSE_OUT, BUSY, DONE});
    end
`else
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      START = 1'b0;
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== ((c == 1) ? 3'b001 : 3'b000) || exp_o !== {PULSE_OUT, BUSY, DONE}) begin
        errs++; $display("FAIL count_zero c%0d got %b model %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
    end
`endif
  endtask

  task automatic test_random;
    for (int c = 0; c < 1500; c++) begin
      START       = ($urandom_range(0, 7) == 0);
      ABORT       = ($urandom_range(0, 29) == 0);
      RSTN        = ($urandom_range(0, 199) != 0);
      HIGH_CYCLES = 8'($urandom_range(0, 4));
      LOW_CYCLES  = 8'($urandom_range(0, 4));
      PULSE_COUNT = 8'($urandom_range(0, 4));
      @(negedge CLK);
      vecs++;
      if ({PULSE_OUT, BUSY, DONE} !== exp_o) begin
        errs++; $display("FAIL random c%0d got %b exp %b", c, {PULSE_OUT, BUSY, DONE}, exp_o);
      end
    end
    START = 1'b0; ABORT = 1'b0; RSTN = 1'b1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_clamp;
    test_abort;
    test_collisions;
    test_count_zero;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Registered pulse-train generator: a single-cycle START strobe launches a train of PULSE_COUNT pulses on PULSE_OUT. Each pulse is HIGH_CYCLES cycles high, and consecutive pulses are separated by LOW_CYCLES cycles low. This is the transmit side of the level/edge path: it drives level signals that downstream two-flop rising/falling edge detectors convert back into single-cycle events. It is used to generate handshakes and stimulus toward blocks that sample edges.

## Interface
- CW, default 8: width of the cycle-count and pulse-count fields.
- CLK input 1: clock; all logic is on the rising edge.
- RSTN input 1: reset, synchronous, active-low.
- START input 1: single-cycle launch strobe; honoured only in IDLE.
- ABORT input 1: terminates an active train.
- HIGH_CYCLES input CW: high-phase length; sampled on accepted START.
- LOW_CYCLES input CW: low-phase length; sampled on accepted START.
- PULSE_COUNT input CW: number of pulses; sampled on accepted START.
- PULSE_OUT output 1: generated pulse train; registered.
- BUSY output 1: high while a train is in progress; registered.
- DONE output 1: one-cycle strobe when a train completes normally; registered.

## Operation
- States are IDLE, HIGH, LOW. BUSY = (state != IDLE). PULSE_OUT = (state == HIGH).
- **Reset:** RSTN low at a clock edge sets state IDLE and clears every output and counter to 0. This holds mid-train as well; no DONE is generated.
- **Accept:** START=1 and ABORT=0 in IDLE latches HIGH_CYCLES, LOW_CYCLES and PULSE_COUNT into internal registers. Later input changes do not affect the running train.
- **Zero lengths:** a latched HIGH or LOW value of 0 is treated as 1, so every edge stays visible to a two-flop detector.
- **Counters:** a phase down-counter is loaded with length-1 on each phase entry. A remaining-pulse counter is loaded with PULSE_COUNT and decremented on each HIGH→LOW or HIGH→IDLE exit.
- **Transitions:**
  - IDLE→HIGH on accept.
  - HIGH→LOW when the phase counter is 0 and remaining > 1.
  - HIGH→IDLE when the phase counter is 0 and remaining == 1; DONE=1 on the next cycle.
  - LOW→HIGH when the phase counter is 0.
- **No trailing gap:** there is no LOW phase after the last pulse.
- **START while BUSY:** ignored, with no queuing.
- **ABORT in HIGH or LOW:** next cycle state is IDLE, PULSE_OUT=0, BUSY=0, DONE stays 0.
- **ABORT in IDLE:** no effect. ABORT and START together in IDLE: ABORT wins and nothing launches.
- **PULSE_COUNT==0:** see Configuration.

## Timing
- Latency: START sampled at edge n gives PULSE_OUT=1 and BUSY=1 from cycle n+1.
- Pulse n is high for max(HIGH,1) cycles; the gap is max(LOW,1) cycles.
- DONE is high for exactly one cycle, the first cycle after the last high cycle. In that cycle PULSE_OUT=0 and BUSY=0.
- Back-to-back trains: a START in the DONE cycle is accepted, so the next train starts after a 1-cycle low gap.
- Total BUSY cycles for N≥1 pulses = N·H + (N-1)·L, with H and L after zero clamping.

## Configuration
- PULSE_TRAIN_CONTINUOUS_EN defined:
  - START with PULSE_COUNT==0 launches an endless train; the remaining counter is not decremented.
  - Only ABORT or reset stops it, and DONE never asserts for such a train.
- Not defined:
  - START with PULSE_COUNT==0 stays in IDLE.
  - DONE=1 for one cycle at n+1, and PULSE_OUT and BUSY stay 0.

## Test plan
- **Reset:** RSTN=0 for 2 cycles with START=1 -> PULSE_OUT, BUSY and DONE are 0 throughout.
- **Basic train:** HIGH=3, LOW=2, COUNT=2, START at edge 0 -> PULSE_OUT=1 in cycles 1–3 and 6–8, 0 in cycles 4–5; BUSY=1 in cycles 1–8; DONE=1 only in cycle 9.
- **Zero clamp and latching:** HIGH=0, LOW=0, COUNT=3, then change inputs to 7 at cycle 2 -> PULSE_OUT toggles 1,0,1,0,1 over cycles 1–5 and DONE=1 at cycle 6.
- **Abort:** HIGH=4, LOW=4, COUNT=5, ABORT at edge 6 -> PULSE_OUT=0 and BUSY=0 from cycle 7, DONE never asserts; a new START at edge 8 launches a fresh train.
- **Collisions:**
  - START during BUSY has no effect on the train length.
  - START+ABORT in IDLE -> no launch.
  - START in the DONE cycle -> PULSE_OUT=1 on the next cycle.
- **COUNT=0:**
  - With the macro: HIGH=1, LOW=1 gives an alternating train for 50 cycles until ABORT, with no DONE.
  - Without the macro: DONE=1 at cycle 1 only and PULSE_OUT stays 0.
